// File: rtl/mac_acc_pkg.sv
// Shared definitions for the MAC result accumulator: default widths, FSM state
// encoding and the signed accumulator limits at the default width.
package mac_acc_pkg;

    localparam int IN_W_DEF  = 18;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ACC   = 1'b1
    } acc_state_t;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_sat_add.sv
// Combinational signed add for the accumulator. With ACC_SAT_EN defined the
// result clamps to the signed range and ovf flags the clamp; otherwise it wraps.
module acc_sat_add
    import mac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    assign raw = a + b;

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow only when both operands share a sign the result lost.
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    assign sum = ovf ? (a[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign ovf = 1'b0;
    assign sum = raw;
`endif

endmodule

// File: rtl/mac_result_accumulator.sv
// Accumulates signed dot-2 partial sums into a dot product closed by in_last and
// holds it in a valid/ready output register. Saturating adds when ACC_SAT_EN is defined.
module mac_result_accumulator
    import mac_acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             fsm_state
);

    // Handshake: a beat moves when in_valid & in_ready on a rising clk edge;
    // a result moves when out_valid & out_ready. Only a closing beat stalls,
    // and only while an unconsumed result would be overwritten.

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, base, addend, sum;
    logic [CNT_W-1:0] cnt_q, cnt_new;
    logic             sat_q, sat_new, ovf, accept;

    assign in_ready  = ~out_valid | out_ready | ~in_last;
    assign accept    = in_valid & in_ready;
    assign fsm_state = state_q;

    // A fresh group starts from zero, so its first add can never overflow.
    assign addend  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign base    = (state_q == S_ACC) ? acc_q : '0;
    assign cnt_new = (state_q == S_ACC) ? ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1))
                                        : CNT_W'(1);
    assign sat_new = ((state_q == S_ACC) & sat_q) | ovf;

    acc_sat_add #(.ACC_W(ACC_W)) u_add (
        .a   (base),
        .b   (addend),
        .sum (sum),
        .ovf (ovf)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? S_EMPTY : S_ACC;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            acc_q <= sum;
            cnt_q <= cnt_new;
            sat_q <= sat_new;
            if (in_last) begin
                out_data  <= sum;
                out_count <= cnt_new;
                out_sat   <= sat_new;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 out_valid <= 1'b0;
        else if (accept && in_last)  out_valid <= 1'b1;
        else if (out_ready)          out_valid <= 1'b0;
    end

endmodule

// File: doc/mac_result_accumulator.md
# mac_result_accumulator

- Sits directly downstream of the dual 8×8 MAC DSP block (`c5_mac_8bitx2`). Takes one signed dot-2 partial sum per beat and accumulates beats into a full dot product until a `last` marker arrives.
- Presents the finished sum on a valid/ready output register, ready for the requantization stage.
- Accumulation of the next group proceeds while a finished result waits, unless that result is still unconsumed when the next group completes.

## Interface

Parameters:
- IN_W, default 18: signed width of the MAC partial sum.
- ACC_W, default 32: signed accumulator and output width, ACC_W > IN_W.
- CNT_W, default 16: width of the beat counter.

Ports:
- clk, in, 1: single clock.
- resetn, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: partial sum valid; aligned by upstream to the DSP output latency.
- in_ready, out, 1: beat accepted when in_valid & in_ready.
- in_data, in, IN_W: signed partial sum.
- in_last, in, 1: beat closes the current dot product.
- out_valid, out, 1: finished result held.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, ACC_W: signed dot-product result.
- out_count, out, CNT_W: number of beats in the group.
- out_sat, out, 1: saturation occurred within the group.

## Operation

- Two states:
  - S_EMPTY: no partial group in flight.
  - S_ACC: partial group held in acc/cnt.
- Accepted beat in S_EMPTY: acc ← sext(in_data), cnt ← 1, sat ← 0.
- Accepted beat in S_ACC: acc ← acc + sext(in_data), cnt ← cnt + 1; cnt saturates at all-ones.
- Accepted beat with in_last:
  - The out register loads the post-add value: out_data ← new sum, out_count ← new cnt, out_sat ← new sat.
  - out_valid ← 1, state ← S_EMPTY.
- Accepted beat without in_last: state ← S_ACC.
- A single-beat group (in_last on the first beat) is legal: out_data = sext(in_data), out_count = 1.
- Output handshake (out_valid & out_ready):
  - Clears out_valid unless a new last beat is accepted in the same cycle.
  - If one is, out_valid stays 1 and the out register holds the new group.
- in_ready = ~out_valid | out_ready | ~in_last. The stall applies only to a closing beat that would overwrite an unconsumed result.
- in_data is ignored when in_valid = 0.
- Arithmetic is two's complement throughout. Wrap vs saturate is set by `ACC_SAT_EN` (see Configuration).

## Timing

- Reset values: state = S_EMPTY, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_count = 0, out_sat = 0.
- With out_valid = 0 after reset, in_ready = 1.
- Latency: a last beat accepted at edge t gives out_valid = 1 with its sum after edge t, i.e. visible in cycle t+1.
- Throughput: one beat per cycle sustained while the consumer keeps out_ready = 1, including back-to-back single-beat groups.
- The first beat of a new group may be accepted in the cycle right after a last beat, and it starts fresh.
- Reset asserted mid-group discards acc, cnt and any held result immediately; no output is produced for that group.
- out_data, out_count and out_sat stay stable while out_valid & ~out_ready.

## Configuration

- `ACC_SAT_EN` defined:
  - Each add clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp in the group sets sat, which is sticky until the group closes.
  - out_sat reports it.
- `ACC_SAT_EN` undefined:
  - Adds wrap modulo 2^ACC_W.
  - out_sat is tied to 0.
  - No clamp logic is synthesized.

## Structure

- Shared package `mac_acc_pkg` holds:
  - Default IN_W, ACC_W and CNT_W localparams.
  - The state enum {S_EMPTY, S_ACC}.
  - ACC_MAX/ACC_MIN constants.
- One sub-module, `acc_sat_add`:
  - Combinational signed add with overflow detect and an optional clamp.
  - Interior guarded by `ACC_SAT_EN`.
- The top holds the FSM, counters, output register and handshake.

## Test plan

1. Reset then three beats of 2, 2, 2 (last on the third) with out_ready = 1: out_valid for 1 cycle, out_data = 6, out_count = 3, out_sat = 0.
2. Single-beat groups −2, 5, 7 on consecutive cycles with out_ready = 1: outputs −2, 5, 7 on consecutive cycles, each with out_count = 1, and in_ready held at 1.
3. Hold out_ready = 0 after group {1, 1}, then feed {3, last = 0}:
   - Beat 3 is accepted; out_data stays 2.
   - A following last beat of 4 sees in_ready = 0.
   - Raise out_ready: 2 is consumed in the same cycle that 4 is accepted; next out_data = 7.
4. With ACC_W = 20 and `ACC_SAT_EN`, feed beats of 131071 ×9 (last on the ninth): out_data = 524287, out_sat = 1. Without the macro, out_data = 131071·9 mod 2^20, reinterpreted as signed, and out_sat = 0.
5. Assert resetn = 0 mid-group after beats {10, 20}, release, then feed {5, last}: out_data = 5, out_count = 1.
6. in_valid = 0 with garbage on in_data for 4 cycles between beats 1 and 1 (last): out_data = 2, out_count = 2.
